adder_pipe_flags: RTL and testbench

- Parametrised, pipelined successor to the team's 16-bit combinational flag adder.
- Performs ADD, ADC, SUB and SBB on WIDTH-bit operands with a valid/ready handshake on both sides.
- Keeps a stored carry flag so that multi-word add/subtract chains run back-to-back.
- Sits between an operand source (sequencer or register file) and a result consumer. Produces registered result and flags: sign, zero, carry, parity, overflow.

---
 rtl/adder_pipe_flags_pkg.sv | 25 ++
 rtl/adder_flags_core.sv | 31 +++
 rtl/adder_pipe_flags.sv | 115 +++++++++++
 tb/tb_adder_pipe_flags.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pipe_flags_pkg.sv
// Shared definitions for the pipelined flag adder: op encoding and flag-vector layout.
package adder_pipe_flags_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_ADC = 2'd1;
    localparam logic [1:0] OP_SUB = 2'd2;
    localparam logic [1:0] OP_SBB = 2'd3;

    localparam int unsigned FLAG_OVERFLOW = 0;
    localparam int unsigned FLAG_PARITY   = 1;
    localparam int unsigned FLAG_CARRY    = 2;
    localparam int unsigned FLAG_ZERO     = 3;
    localparam int unsigned FLAG_SIGN     = 4;
    localparam int unsigned NUM_FLAGS     = 5;

    // SUB/SBB invert operand B; ADC/SBB consume the stored carry.
    function automatic logic op_is_sub(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_uses_carry(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/adder_flags_core.sv
// Combinational WIDTH-bit add/subtract with carry-in, producing result and five flags.
module adder_flags_core
    import adder_pipe_flags_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 sub,
    input  logic                 cin,
    output logic [WIDTH-1:0]     y_c,
    output logic [NUM_FLAGS-1:0] flags_c
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    // Subtraction reuses the adder with B inverted; carry flag then reports borrow.
    always_comb begin
        b_eff   = sub ? ~b : b;
        sum     = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(cin);
        y_c     = sum[WIDTH-1:0];
        flags_c = '0;
        flags_c[FLAG_SIGN]     = sum[WIDTH-1];
        flags_c[FLAG_ZERO]     = (sum[WIDTH-1:0] == '0);
        flags_c[FLAG_CARRY]    = sum[WIDTH] ^ sub;
        flags_c[FLAG_PARITY]   = ~^sum[WIDTH-1:0];
        flags_c[FLAG_OVERFLOW] = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/adder_pipe_flags.sv
// Two-stage pipelined ADD/ADC/SUB/SBB with valid/ready handshake and stored carry flag.
module adder_pipe_flags
    import adder_pipe_flags_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flag_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             sign,
    output logic             zero,
    output logic             carry,
    output logic             parity,
    output logic             overflow,
    output logic             cflag
);

    logic                 s1_valid;
    logic [1:0]           s1_op;
    logic [WIDTH-1:0]     s1_a;
    logic [WIDTH-1:0]     s1_b;
    logic                 s2_valid;
    logic [WIDTH-1:0]     s2_y;
    logic [NUM_FLAGS-1:0] s2_flags;

    logic                 s2_adv_c;
    logic                 s2_load_c;
    logic                 in_fire_c;
    logic                 cin_c;
    logic [WIDTH-1:0]     y_c;
    logic [NUM_FLAGS-1:0] flags_c;

    assign s2_adv_c  = !s2_valid || out_ready;
    assign s2_load_c = s2_adv_c && s1_valid;
    assign in_ready  = !s1_valid || s2_adv_c;
    assign in_fire_c = in_valid && in_ready;

    // SBB borrows when cflag is set, so its carry-in is the inverted flag.
    always_comb begin
        cin_c = 1'b0;
        if (op_is_sub(s1_op)) begin
            cin_c = op_uses_carry(s1_op) ? !cflag : 1'b1;
        end else begin
            cin_c = op_uses_carry(s1_op) ? cflag : 1'b0;
        end
    end

    adder_flags_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a       (s1_a),
        .b       (s1_b),
        .sub     (op_is_sub(s1_op)),
        .cin     (cin_c),
        .y_c     (y_c),
        .flags_c (flags_c)
    );

    // S1: operand register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_ADD;
            s1_a     <= '0;
            s1_b     <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (in_fire_c) begin
                s1_op <= op;
                s1_a  <= a;
                s1_b  <= b;
            end
        end
    end

    // S2: result/flag register; cflag follows every load so chained ops see it at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_y     <= '0;
            s2_flags <= '0;
            cflag    <= 1'b0;
        end else begin
            if (s2_adv_c) begin
                s2_valid <= s1_valid;
            end
            if (s2_load_c) begin
                s2_y     <= y_c;
                s2_flags <= flags_c;
                cflag    <= flags_c[FLAG_CARRY];
            end else if (flag_clr) begin
                cflag <= 1'b0;
            end
        end
    end

    assign out_valid = s2_valid;
    assign y         = s2_y;
    assign sign      = s2_flags[FLAG_SIGN];
    assign zero      = s2_flags[FLAG_ZERO];
    assign carry     = s2_flags[FLAG_CARRY];
    assign parity    = s2_flags[FLAG_PARITY];
    assign overflow  = s2_flags[FLAG_OVERFLOW];

endmodule

// File: tb/tb_adder_pipe_flags.sv
// Directed and randomized bench for adder_pipe_flags against an arithmetic reference model.
module tb_adder_pipe_flags;

    localparam int unsigned W = 16;

    typedef struct {
        logic [W-1:0] y;
        logic [4:0]   f;   // {sign, zero, carry, parity, overflow}
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flag_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         sign, zero, carry, parity, overflow, cflag;

    int   n_cmp = 0;
    int   n_err = 0;
    logic hs_in, ov_seen, ir_seen;
    logic mcflag;
    res_t expq[$];
    res_t out_log[$];

    adder_pipe_flags #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .flag_clr(flag_clr),
        .out_valid(out_valid), .out_ready(out_ready), .y(y),
        .sign(sign), .zero(zero), .carry(carry), .parity(parity),
        .overflow(overflow), .cflag(cflag)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, signed range check for overflow.
    function automatic res_t model(input logic [1:0] mop, input logic [W-1:0] ma,
                                   input logic [W-1:0] mb, input logic c);
        res_t   r;
        longint ua = longint'(ma);
        longint ub = longint'(mb);
        longint sa = longint'($signed(ma));
        longint sb = longint'($signed(mb));
        longint cc = c ? 64'sd1 : 64'sd0;
        longint ur, sr;
        logic   cy;
        case (mop)
            2'd0:    begin ur = ua + ub;      sr = sa + sb;      end
            2'd1:    begin ur = ua + ub + cc; sr = sa + sb + cc; end
            2'd2:    begin ur = ua - ub;      sr = sa - sb;      end
            default: begin ur = ua - ub - cc; sr = sa - sb - cc; end
        endcase
        cy  = (mop < 2) ? (ur > 65535) : (ur < 0);
        r.y = W'(ur & 64'hFFFF);
        r.f = {r.y[W-1], r.y == 0, cy, ($countones(r.y) % 2) == 0,
               (sr > 32767) || (sr < -32768)};
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, score output beats, model accepted input beats.
    task automatic tick();
        res_t e;
        @(negedge clk);
        ov_seen = out_valid;
        ir_seen = in_ready;
        hs_in   = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = expq.pop_front();
                check("sb_y", 32'(y), 32'(e.y));
                check("sb_flags", 32'({sign, zero, carry, parity, overflow}), 32'(e.f));
                out_log.push_back('{y, {sign, zero, carry, parity, overflow}});
            end
        end
        if (hs_in) begin
            e = model(op, a, b, mcflag);
            expq.push_back(e);
            mcflag = e.f[2];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] sop, input logic [W-1:0] sa, input logic [W-1:0] sb);
        logic done = 1'b0;
        in_valid = 1'b1;
        op = sop;
        a  = sa;
        b  = sb;
        for (int i = 0; i < 50 && !done; i++) begin
            tick();
            done = hs_in;
        end
        if (!done) check("send_timeout", 32'(done), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && expq.size() > 0; i++) tick();
        check("drain_empty", 32'(expq.size()), 32'd0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return '1;
            2:       return 16'h8000;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int   acc;
        logic done;
        rst_n = 1'b0; in_valid = 1'b0; op = 2'd0; a = '0; b = '0;
        flag_clr = 1'b0; out_ready = 1'b1; mcflag = 1'b0; hs_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y_flags", 32'({y, sign, zero, carry, parity, overflow, cflag}), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", 32'(ir_seen), 32'd1);

        // Test 1: latency and overflow
        send(2'd0, 16'h4000, 16'h4000);
        tick();
        check("t1_lat_cycle1", 32'(ov_seen), 32'd0);
        tick();
        check("t1_lat_cycle2", 32'(ov_seen), 32'd1);
        check("t1_y", 32'(out_log[$].y), 32'h8000);
        check("t1_flags", 32'(out_log[$].f), 32'(5'b10001));

        // Test 2: zero result with carry
        send(2'd0, 16'h1234, 16'hEDCC);
        drain();
        check("t2_y", 32'(out_log[$].y), 32'h0000);
        check("t2_flags", 32'(out_log[$].f), 32'(5'b01110));
        check("t2_cflag", 32'(cflag), 32'd1);

        // Test 3: 32-bit chain back-to-back
        send(2'd0, 16'hFFFF, 16'h0001);
        send(2'd1, 16'hFFFF, 16'h0000);
        drain();
        check("t3_b1", 32'({out_log[$-1].y, out_log[$-1].f[2]}), 32'h00001);
        check("t3_b2", 32'({out_log[$].y, out_log[$].f[2]}), 32'h00001);

        // Test 4: SUB borrow then SBB
        send(2'd2, 16'h0003, 16'h0005);
        send(2'd3, 16'h0001, 16'h0000);
        drain();
        check("t4_sub_y", 32'(out_log[$-1].y), 32'hFFFE);
        check("t4_sub_flags", 32'(out_log[$-1].f), 32'(5'b10100));
        check("t4_sbb_y", 32'(out_log[$].y), 32'h0000);
        check("t4_sbb_zc", 32'(out_log[$].f[3:2]), 32'(2'b10));

        // flag_clr coinciding with the S2 load loses; alone it clears
        send(2'd0, 16'hFFFF, 16'h0001);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        check("clr_vs_load", 32'(cflag), 32'd1);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        mcflag = 1'b0;
        check("clr_alone", 32'(cflag), 32'd0);
        drain();
        send(2'd2, 16'h8000, 16'h0001);
        drain();
        check("sub_ovf", 32'({out_log[$].y, out_log[$].f[0]}), 32'({16'h7FFF, 1'b1}));

        // Test 5: backpressure
        out_ready = 1'b0;
        send(2'd0, 16'h0001, 16'h0001);
        send(2'd0, 16'h0002, 16'h0002);
        in_valid = 1'b1; op = 2'd0; a = 16'h0003; b = 16'h0003;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_in_ready_low", 32'(ir_seen), 32'd0);
            check("t5_y_stable", 32'({out_valid, y}), 32'({1'b1, 16'h0002}));
        end
        out_ready = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            done = hs_in;
        end
        check("t5_third_accepted", 32'(done), 32'd1);
        in_valid = 1'b0;
        drain();
        check("t5_order", 32'({out_log[$-2].y, out_log[$-1].y, out_log[$].y}),
              32'(48'h0002_0004_0006));

        // Test 6: reset with both stages full and cflag set
        send(2'd0, 16'hFFFF, 16'h0001);
        drain();
        check("t6_cflag_set", 32'(cflag), 32'd1);
        out_ready = 1'b0;
        send(2'd0, 16'h0010, 16'h0020);
        send(2'd0, 16'h0030, 16'h0040);
        check("t6_full", 32'({out_valid, in_ready}), 32'(2'b10));
        rst_n = 1'b0;
        #1;
        check("t6_rst_out", 32'({out_valid, cflag}), 32'd0);
        check("t6_rst_flags", 32'({y, sign, zero, carry, parity, overflow}), 32'd0);
        expq.delete();
        mcflag = 1'b0;
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        check("t6_in_ready", 32'(ir_seen), 32'd1);
        send(2'd1, 16'h0001, 16'h0001);
        drain();
        check("t6_adc_y", 32'(out_log[$].y), 32'h0002);

        // Randomized traffic with random backpressure
        acc = 0;
        for (int i = 0; i < 6000 && acc < 300; i++) begin
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                op = 2'($urandom_range(0, 3));
                a  = pick();
                b  = pick();
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (hs_in) begin
                acc++;
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        check("rand_beats", 32'(acc), 32'd300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
